// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller arbiter.
// Size codes, RAM direction, FSM states, size decode and read extension.
package mem_ctrl_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         SZ_B:    return 3'd1;
         SZ_H:    return 3'd2;
         SZ_W:    return 3'd4;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] extend(
      input logic [31:0] d,
      input logic [1:0]  sz,
      input logic        sgn
   );
      case (sz)
         SZ_B:    return {{24{sgn & d[7]}}, d[7:0]};
         SZ_H:    return {{16{sgn & d[15]}}, d[15:0]};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Requester arbiter: fixed priority or round-robin, one-hot grant.
// The pointer holds the next search start and moves only on a grant.
module mem_arbiter
#(
   parameter int NUM_CH   = 2,
   parameter int ARB_MODE = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              en,
   output logic [NUM_CH-1:0] grant
);

   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nx;
   int            j;

   // Scan from the highest offset down so the lowest offset wins.
   always_comb begin
      grant  = '0;
      ptr_nx = ptr;
      j      = 0;
      for (int off = NUM_CH - 1; off >= 0; off--) begin
         j = off;
         if (ARB_MODE != 0) j = j + int'(ptr);
         if (j >= NUM_CH) j = j - NUM_CH;
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            ptr_nx   = (j == NUM_CH - 1) ? '0 : PW'(j + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr <= '0;
      else if (en && |grant) ptr <= ptr_nx;
   end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Multi-channel byte-serial RAM controller: 1/2/4-byte reads and writes
// as serial byte beats, with abort of reads and IO-region write stalls.
module mem_ctrl_arb
   import mem_ctrl_pkg::*;
#(
   parameter int          NUM_CH   = 2,
   parameter int          ADDR_W   = 32,
   parameter int          ARB_MODE = 0,
   parameter logic [31:0] IO_BASE  = 32'h30000
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req_valid,
   input  logic [NUM_CH-1:0]        req_we,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*2-1:0]      req_size,
   input  logic [NUM_CH-1:0]        req_signed,
   input  logic [NUM_CH*32-1:0]     req_wdata,
   input  logic [NUM_CH-1:0]        abort,
   output logic [NUM_CH-1:0]        rsp_valid,
   output logic [31:0]              rsp_data,
   output logic                     busy,
   input  logic                     io_buffer_full,
   input  logic [7:0]               ram_din,
   output logic [7:0]               ram_dout,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic                     ram_wr
);

   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t              state;
   state_t              state_nx;
   logic [2:0]          cnt;
   logic [2:0]          cnt_nx;
   logic [PW-1:0]       own;
   logic [PW-1:0]       gidx;
   logic [ADDR_W-1:0]   addr;
   logic [1:0]          size;
   logic                sgn;
   logic                we;
   logic [31:0]         wdata;
   logic [31:0]         rbuf;
   logic [NUM_CH-1:0]   grant;
   logic                gnt_en;
   logic                any_gnt;
   logic [2:0]          nb;
   logic [2:0]          roff;
   logic [1:0]          bsel;
   logic                stall;
   logic                own_abort;

   assign gnt_en  = (state == ST_IDLE);
   assign any_gnt = |grant;
   assign nb      = size_bytes(size);
   assign stall   = (addr >= ADDR_W'(IO_BASE)) && io_buffer_full;
   assign roff    = (cnt < nb) ? cnt : nb - 3'd1;
   assign bsel    = cnt[1:0] - 2'd1;

   mem_arbiter #(
      .NUM_CH   (NUM_CH),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req_valid & ~abort),
      .en    (gnt_en),
      .grant (grant)
   );

   always_comb begin
      gidx      = '0;
      own_abort = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant[c]) gidx = PW'(c);
         if (own == PW'(c)) own_abort = abort[c];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      ram_addr  = '0;
      ram_wr    = RAM_READ;
      ram_dout  = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      busy      = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (any_gnt) begin
               state_nx = req_we[gidx] ? ST_WRITE : ST_READ;
               cnt_nx   = '0;
            end
         end
         ST_READ: begin
            ram_addr = addr + ADDR_W'(roff);
            if (own_abort) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end else if (cnt == nb) begin
               state_nx = ST_RESP;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 3'd1;
            end
         end
         ST_WRITE: begin
            ram_addr = addr + ADDR_W'(cnt);
            // An IO stall freezes the beat with the strobe dropped.
            if (!stall) begin
               ram_wr   = RAM_WRITE;
               ram_dout = wdata[{cnt[1:0], 3'b000} +: 8];
               if (cnt == nb - 3'd1) begin
                  state_nx = ST_RESP;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 3'd1;
               end
            end
         end
         ST_RESP: begin
            for (int c = 0; c < NUM_CH; c++) begin
               rsp_valid[c] = (own == PW'(c));
            end
            rsp_data = we ? 32'h0 : extend(rbuf, size, sgn);
            state_nx = ST_IDLE;
            cnt_nx   = '0;
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         own   <= '0;
         we    <= 1'b0;
         addr  <= '0;
         size  <= '0;
         sgn   <= 1'b0;
         wdata <= '0;
         rbuf  <= '0;
      end else begin
         if (gnt_en && any_gnt) begin
            own   <= gidx;
            we    <= req_we[gidx];
            addr  <= req_addr[gidx*ADDR_W +: ADDR_W];
            size  <= req_size[gidx*2 +: 2];
            sgn   <= req_signed[gidx];
            wdata <= req_wdata[gidx*32 +: 32];
            rbuf  <= '0;
         end
         // RAM returns a byte one cycle after its address beat.
         if (state == ST_READ && !own_abort && cnt != 3'd0) begin
            rbuf[{bsel, 3'b000} +: 8] <= ram_din;
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Bench for mem_ctrl_arb: two instances (fixed priority, round-robin)
// on identical inputs, each with its own byte RAM.
module tb_mem_ctrl_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_we;
   logic [63:0] req_addr;
   logic [3:0]  req_size;
   logic [1:0]  req_signed;
   logic [63:0] req_wdata;
   logic [1:0]  abort;
   logic        io_buffer_full;

   logic [1:0]  rsp_valid_a, rsp_valid_b;
   logic [31:0] rsp_data_a, rsp_data_b;
   logic        busy_a, busy_b;
   logic [7:0]  ram_din_a, ram_din_b;
   logic [7:0]  ram_dout_a, ram_dout_b;
   logic [31:0] ram_addr_a, ram_addr_b;
   logic        ram_wr_a, ram_wr_b;

   logic        pl_en;
   logic [17:0] pl_a;
   logic [7:0]  pl_d;

   logic [7:0]  mem_a [0:262143];
   logic [7:0]  mem_b [0:262143];
   logic [7:0]  mref  [0:262143];

   logic [31:0] trace_addr [0:63];
   logic        trace_wr   [0:63];
   int          last_lat;
   logic [31:0] last_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_ctrl_arb #(
      .NUM_CH(2), .ADDR_W(32), .ARB_MODE(0), .IO_BASE(32'h30000)
   ) u_fix (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata), .abort(abort),
      .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .busy(busy_a),
      .io_buffer_full(io_buffer_full), .ram_din(ram_din_a),
      .ram_dout(ram_dout_a), .ram_addr(ram_addr_a), .ram_wr(ram_wr_a)
   );

   mem_ctrl_arb #(
      .NUM_CH(2), .ADDR_W(32), .ARB_MODE(1), .IO_BASE(32'h30000)
   ) u_rr (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata), .abort(abort),
      .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .busy(busy_b),
      .io_buffer_full(io_buffer_full), .ram_din(ram_din_b),
      .ram_dout(ram_dout_b), .ram_addr(ram_addr_b), .ram_wr(ram_wr_b)
   );

   always @(posedge clk) begin
      ram_din_a <= mem_a[ram_addr_a[17:0]];
      if (pl_en) mem_a[pl_a] <= pl_d;
      else if (ram_wr_a) mem_a[ram_addr_a[17:0]] <= ram_dout_a;
   end

   always @(posedge clk) begin
      ram_din_b <= mem_b[ram_addr_b[17:0]];
      if (pl_en) mem_b[pl_a] <= pl_d;
      else if (ram_wr_b) mem_b[ram_addr_b[17:0]] <= ram_dout_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [17:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en = 1'b1;
      pl_a  = a;
      pl_d  = d;
      mref[a] = d;
   endtask

   task automatic poke_done();
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Reference: reads take N+2 cycles to the response; writes need N
   // unstalled beats starting at t+1, then the response cycle.
   task automatic txn(input int ch, input bit w, input logic [31:0] a,
                      input logic [1:0] sz, input bit sg,
                      input logic [31:0] wd, input logic [63:0] pat,
                      input bit drop, input string tag);
      int          nb;
      int          n;
      int          beats;
      int          exp_lat;
      logic [31:0] exp_d;
      bit          io;
      bit          done;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      io = (a >= 32'h30000);
      exp_d = 32'h0;
      if (w) begin
         n = 1;
         beats = nb;
         while (beats > 0) begin
            if (!(io && pat[n])) beats--;
            n++;
         end
         exp_lat = n;
      end else begin
         exp_lat = nb + 2;
         for (int i = 0; i < nb; i++)
            exp_d = exp_d | (32'(mref[a[17:0] + 18'(i)]) << (8 * i));
         if (sg && nb == 1 && exp_d[7])  exp_d = exp_d | 32'hFFFFFF00;
         if (sg && nb == 2 && exp_d[15]) exp_d = exp_d | 32'hFFFF0000;
      end
      @(negedge clk);
      req_we[ch]           = w;
      req_addr[ch*32 +: 32] = a;
      req_size[ch*2 +: 2]  = sz;
      req_signed[ch]       = sg;
      req_wdata[ch*32 +: 32] = wd;
      req_valid[ch]        = 1'b1;
      io_buffer_full       = pat[0];
      done = 0;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clk);
         io_buffer_full = pat[c];
         if (drop && c == 2) req_valid[ch] = 1'b0;
         #1;
         trace_addr[c] = ram_addr_a;
         trace_wr[c]   = ram_wr_a;
         if (rsp_valid_a != 2'b00) begin
            done      = 1;
            last_lat  = c;
            last_data = rsp_data_a;
            chk({tag, "_lat"}, 32'(c), 32'(exp_lat));
            chk({tag, "_ch"}, 32'(rsp_valid_a), 32'(1 << ch));
            chk({tag, "_data"}, rsp_data_a, exp_d);
            req_valid[ch] = 1'b0;
         end
      end
      if (!done) begin
         chk({tag, "_timeout"}, 32'(done), 32'd1);
         req_valid[ch] = 1'b0;
      end
      if (w) begin
         for (int i = 0; i < nb; i++)
            mref[a[17:0] + 18'(i)] = wd[8*i +: 8];
      end
      io_buffer_full = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  q_a [$];
      logic [1:0]  q_b [$];
      logic [31:0] d_b [$];
      logic [63:0] pat;
      logic [31:0] a;
      int          got;
      int          bad1;

      rst = 1'b0;
      req_valid = '0; req_we = '0; req_addr = '0; req_size = '0;
      req_signed = '0; req_wdata = '0; abort = '0;
      io_buffer_full = 1'b0;
      pl_en = 1'b0; pl_a = '0; pl_d = '0;
      for (int i = 0; i < 64; i++) trace_addr[i] = '0;
      for (int i = 0; i < 64; i++) trace_wr[i] = 1'b0;
      last_lat = 0; last_data = '0;

      @(negedge clk); #1;
      chk("rst_rsp_valid", 32'(rsp_valid_a), 32'h0);
      chk("rst_rsp_data", rsp_data_a, 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_ram_dout", 32'(ram_dout_a), 32'h0);
      chk("rst_ram_addr", ram_addr_a, 32'h0);
      chk("rst_ram_wr", 32'(ram_wr_a), 32'h0);
      chk("rst_busy_rr", 32'(busy_b), 32'h0);

      poke(18'h100, 8'h11); poke(18'h101, 8'h22);
      poke(18'h102, 8'h33); poke(18'h103, 8'h44);
      poke(18'h104, 8'h55); poke(18'h105, 8'h66);
      poke(18'h106, 8'h77); poke(18'h107, 8'h88);
      poke(18'h200, 8'h80);
      poke(18'h210, 8'hFF); poke(18'h211, 8'h7F);
      for (int i = 0; i < 4; i++) poke(18'h500 + 18'(i), 8'h5A);
      for (int i = 0; i < 4; i++) poke(18'h30004 + 18'(i), 8'h00);
      for (int i = 0; i < 64; i++) poke(18'h1000 + 18'(i), 8'($urandom));
      for (int i = 0; i < 64; i++) poke(18'h30100 + 18'(i), 8'($urandom));
      poke_done();
      rst = 1'b1;

      txn(0, 0, 32'h100, 2'd2, 0, 32'h0, 64'h0, 0, "rd_w");
      for (int c = 1; c <= 4; c++)
         chk("rd_w_addr", trace_addr[c], 32'h100 + 32'(c - 1));
      chk("rd_w_lat6", 32'(last_lat), 32'd6);
      chk("rd_w_val", last_data, 32'h44332211);

      txn(0, 0, 32'h200, 2'd0, 1, 32'h0, 64'h0, 0, "rd_sb");
      chk("rd_sb_val", last_data, 32'hFFFFFF80);
      chk("rd_sb_lat3", 32'(last_lat), 32'd3);
      txn(0, 0, 32'h200, 2'd0, 0, 32'h0, 64'h0, 0, "rd_ub");
      chk("rd_ub_val", last_data, 32'h00000080);
      txn(0, 0, 32'h210, 2'd1, 1, 32'h0, 64'h0, 0, "rd_sh");
      chk("rd_sh_val", last_data, 32'h00007FFF);

      txn(0, 1, 32'h30004, 2'd2, 0, 32'hDEADBEEF, 64'h1C, 0, "io_w");
      chk("io_lat8", 32'(last_lat), 32'd8);
      chk("io_wr_b1", 32'(trace_wr[1]), 32'd1);
      for (int c = 2; c <= 4; c++)
         chk("io_wr_stall", 32'(trace_wr[c]), 32'd0);
      chk("io_byte0", 32'(mem_a[18'h30004]), 32'hEF);
      chk("io_byte1", 32'(mem_a[18'h30005]), 32'hBE);
      chk("io_byte2", 32'(mem_a[18'h30006]), 32'hAD);
      chk("io_byte3", 32'(mem_a[18'h30007]), 32'hDE);

      @(negedge clk);
      req_we[1] = 1'b0; req_addr[63:32] = 32'h100;
      req_size[3:2] = 2'd2; req_signed[1] = 1'b0; req_valid[1] = 1'b1;
      @(negedge clk);
      req_we[0] = 1'b0; req_addr[31:0] = 32'h104;
      req_size[1:0] = 2'd2; req_signed[0] = 1'b0; req_valid[0] = 1'b1;
      #1 chk("ab_busy", 32'(busy_a), 32'd1);
      @(negedge clk);
      abort[1] = 1'b1;
      @(negedge clk);
      abort[1] = 1'b0; req_valid[1] = 1'b0;
      #1 chk("ab_idle", 32'(busy_a), 32'd0);
      got = 0; bad1 = 0;
      for (int c = 4; c <= 20 && got == 0; c++) begin
         @(negedge clk); #1;
         if (rsp_valid_a[1]) bad1++;
         if (rsp_valid_a[0]) begin
            got = 1;
            chk("ab_ch0_lat", 32'(c), 32'd9);
            chk("ab_ch0_data", rsp_data_a, 32'h88776655);
            req_valid[0] = 1'b0;
         end
      end
      chk("ab_ch0_got", 32'(got), 32'd1);
      chk("ab_no_rsp1", 32'(bad1), 32'd0);
      req_valid = '0;

      @(negedge clk);
      req_we[0] = 1'b1; req_addr[31:0] = 32'h500; req_size[1:0] = 2'd2;
      req_wdata[31:0] = 32'hA1B2C3D4; req_valid[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_rsp_valid", 32'(rsp_valid_a), 32'h0);
      chk("mrst_rsp_data", rsp_data_a, 32'h0);
      chk("mrst_busy", 32'(busy_a), 32'h0);
      chk("mrst_ram_dout", 32'(ram_dout_a), 32'h0);
      chk("mrst_ram_addr", ram_addr_a, 32'h0);
      chk("mrst_ram_wr", 32'(ram_wr_a), 32'h0);
      req_valid = '0;
      req_we[0] = 1'b0;
      mref[18'h500] = 8'hD4;
      mref[18'h501] = 8'hC3;
      @(negedge clk);
      rst = 1'b1;
      chk("mrst_b0", 32'(mem_a[18'h500]), 32'hD4);
      chk("mrst_b2", 32'(mem_a[18'h502]), 32'h5A);
      txn(0, 0, 32'h500, 2'd2, 0, 32'h0, 64'h0, 0, "mrst_rd");
      chk("mrst_rd_val", last_data, 32'h5A5AC3D4);

      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      req_we = 2'b00; req_size = 4'b1010; req_signed = 2'b00;
      req_addr = {32'h104, 32'h100};
      req_valid = 2'b11;
      for (int c = 0; c < 60 && (q_a.size() < 4 || q_b.size() < 4); c++) begin
         @(negedge clk); #1;
         if (rsp_valid_a != 2'b00 && q_a.size() < 4) q_a.push_back(rsp_valid_a);
         if (rsp_valid_b != 2'b00 && q_b.size() < 4) begin
            q_b.push_back(rsp_valid_b);
            d_b.push_back(rsp_data_b);
         end
         if (q_a.size() >= 4 && q_b.size() >= 4) req_valid = 2'b00;
      end
      req_valid = 2'b00;
      chk("rr_cnt_fix", 32'(q_a.size()), 32'd4);
      chk("rr_cnt_rr", 32'(q_b.size()), 32'd4);
      for (int i = 0; i < 4 && i < q_a.size(); i++)
         chk("fix_grant", 32'(q_a[i]), 32'h1);
      for (int i = 0; i < 4 && i < q_b.size(); i++) begin
         chk("rr_grant", 32'(q_b[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_data", d_b[i],
             (i % 2 == 0) ? 32'h44332211 : 32'h88776655);
      end

      for (int k = 0; k < 24; k++) begin
         a = ($urandom_range(0, 1) == 0) ? 32'h1000 : 32'h30100;
         a = a + 32'($urandom_range(0, 60));
         pat = {$urandom, $urandom} & {$urandom, $urandom};
         txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), a,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, pat, 1'($urandom_range(0, 1)), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_ctrl_arb.md
Name: mem_ctrl_arb

Overview:
- Parametrised successor of the byte-serial memory controller.
- Arbitrates NUM_CH requesters onto the single 8-bit RAM port, e.g. ch0 = data/MEM stage, ch1 = i-cache.
- Performs 1/2/4-byte reads (optionally sign-extended) and writes as serial byte beats.
- Adds round-robin mode, per-channel abort of in-flight reads, and stalling of IO-region writes while io_buffer_full is high.

Parameters:
- NUM_CH, 2, number of requester channels (1..8).
- ADDR_W, 32, address width.
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- IO_BASE, 32'h30000, addresses >= IO_BASE form the IO region.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request; held with its fields stable until that channel's rsp_valid or abort.
- req_we  in  NUM_CH  1 = write, 0 = read.
- req_addr  in  NUM_CH*ADDR_W  byte address; channel c occupies slice [c*ADDR_W +: ADDR_W].
- req_size  in  NUM_CH*2  size code: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- req_signed  in  NUM_CH  sign-extend read data.
- req_wdata  in  NUM_CH*32  write data, little-endian.
- abort  in  NUM_CH  cancel the channel's in-flight read.
- rsp_valid  out  NUM_CH  one-cycle completion pulse, one-hot.
- rsp_data  out  32  read data, qualified by rsp_valid; zero for writes.
- busy  out  1  high whenever state != IDLE.
- io_buffer_full  in  1  IO sink cannot accept a byte.
- ram_din  in  8  RAM read byte, valid one cycle after its address.
- ram_dout  out  8  RAM write byte.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wr  out  1  1 = write, 0 = read.

Behaviour:
- Reset (async, rst=0): state = IDLE, byte counter = 0, RR pointer = 0. All outputs 0: rsp_valid, rsp_data, busy, ram_dout, ram_addr, ram_wr.
- Reset mid-transaction aborts it silently; partially written bytes stay written.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - If any req_valid is set, the arbiter picks owner k at the clock edge and latches addr/size/signed/wdata/we; N = 1/2/4 bytes.
  - Next state is READ or WRITE, counter = 0.
  - ram_addr = 0, ram_wr = 0.
- Arbitration:
  - Fixed mode: lowest index wins.
  - Round-robin mode: search starts at (last owner + 1) mod NUM_CH; the pointer updates only on a grant.
- READ, counter i = 0..N:
  - For i < N: ram_addr = addr + i, ram_wr = 0.
  - ram_din is captured into byte i-1 for i >= 1.
  - At i = N: ram_addr holds addr + N - 1; capture the last byte, then go to RESP.
- WRITE, counter i = 0..N-1:
  - ram_addr = addr + i, ram_dout = wdata byte i, ram_wr = 1.
  - After i = N-1, go to RESP.
- IO stall: if addr >= IO_BASE and io_buffer_full = 1 during WRITE:
  - ram_wr = 0, ram_dout = 0, counter holds.
  - The beat resumes on the first cycle the flag is low.
  - Reads are never stalled.
- RESP:
  - rsp_valid[k] = 1 for exactly one cycle.
  - rsp_data = assembled little-endian value: zero-extended, or sign-extended from bit 7 (byte) or bit 15 (half) when signed.
  - Next state is always IDLE, so the requester's still-high req_valid is never re-granted.
- Latency, with the grant edge at the end of IDLE cycle t:
  - Word read: address beats in cycles t+1..t+4, last capture in t+5, rsp_valid in t+6.
  - Byte read: rsp_valid in t+3.
  - Word write: rsp_valid in t+5.
  - Unstalled N-byte write: rsp_valid in t+N+1.
  - Minimum issue interval between transactions: RESP + IDLE.
- Abort:
  - abort[k] on the owner during READ ends the transaction; next state is IDLE and no rsp_valid is issued.
  - Abort on the owner during WRITE or RESP is ignored, and so is abort on a non-owner.
  - A request that has abort asserted in the same IDLE cycle is not granted.
- A requester dropping req_valid mid-transaction has no effect; the transaction completes and rsp_valid still pulses.

Decomposition:
- Package mem_ctrl_pkg holds:
  - size codes SZ_B/SZ_H/SZ_W;
  - RAM_READ = 0, RAM_WRITE = 1;
  - FSM state encodings;
  - a size-to-byte-count function;
  - a sign/zero-extend function.
- Sub-module mem_arbiter (NUM_CH, ARB_MODE) is the natural split: inputs req & ~abort plus a grant-enable; outputs a one-hot grant and holds the RR pointer.

Test Plan:
- ch0 reads a word at 0x100 (RAM 0x100..0x103 = 11,22,33,44), ARB_MODE = 0 -> ram_addr 0x100..0x103 in cycles t+1..t+4, rsp_valid[0] at t+6, rsp_data = 0x44332211.
- ch0 signed byte read at 0x200 = 0x80 -> rsp_data = 0xFFFFFF80. Same read unsigned -> 0x00000080. Signed half 0x7FFF -> 0x00007FFF.
- ch0 and ch1 request continuously: ARB_MODE = 0 -> ch0 granted every time; ARB_MODE = 1 -> grants alternate 0,1,0,1.
- ch0 word write 0xDEADBEEF to 0x30004 with io_buffer_full high for 3 cycles after beat 1 -> bytes EF,BE,AD,DE; ram_wr low during the stall; rsp_valid[0] at t+8.
- ch1 word read, abort[1] pulsed in t+2 -> next cycle IDLE, no rsp_valid[1]; a pending ch0 request is granted at that IDLE.
- rst driven low in t+3 of a word write -> all outputs 0 immediately (async); after release, a new request completes normally.
